// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port among NUM_REQ masters.
// The winning request is captured in a one-deep registered write stage that drives the bank.
module regfile_wr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 32,
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      rf_write_en,
   output logic [ADDR_W-1:0]         rf_add_line,
   output logic [DATA_W-1:0]         rf_data,
   output logic [IDX_W-1:0]          last_master,
   output logic                      busy
);

   localparam int CW = IDX_W + 1;

   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              write_en_q, write_en_d;
   logic [ADDR_W-1:0] add_line_q, add_line_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [IDX_W-1:0]  last_master_q, last_master_d;

   logic              found;
   logic [IDX_W-1:0]  winner;
   logic [CW-1:0]     cand;
   logic              grant_ok;
   logic              xfer;

   // Scan requesters starting at the pointer; the first hit wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + CW'(k);
         if (cand >= CW'(NUM_REQ)) begin
            cand = cand - CW'(NUM_REQ);
         end
         if (!found && req[cand[IDX_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[IDX_W-1:0];
         end
      end
   end

   assign grant_ok = found && enable && !reset;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
         assign gnt[gi] = grant_ok && (winner == IDX_W'(gi));
      end
   endgenerate

   assign xfer = |(req & gnt);

   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      write_en_d    = 1'b0;
      add_line_d    = add_line_q;
      data_d        = data_q;
      last_master_d = last_master_q;
      if (xfer) begin
         write_en_d    = 1'b1;
         add_line_d    = req_addr[winner*ADDR_W +: ADDR_W];
         data_d        = req_data[winner*DATA_W +: DATA_W];
         last_master_d = winner;
         // The winner drops to lowest priority for the next round.
         rr_ptr_d      = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q      <= '0;
         write_en_q    <= 1'b0;
         add_line_q    <= '0;
         data_q        <= '0;
         last_master_q <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         write_en_q    <= write_en_d;
         add_line_q    <= add_line_d;
         data_q        <= data_d;
         last_master_q <= last_master_d;
      end
   end

   assign rf_write_en = write_en_q;
   assign rf_add_line = add_line_q;
   assign rf_data     = data_q;
   assign last_master = last_master_q;
   assign busy        = (|req) || write_en_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, single master, round robin, wrap/skip, enable, same-address.
// A 16x32 bank model captures every write strobe mid-cycle.
module tb_regfile_wr_arbiter;

   logic         clk;
   logic         reset;
   logic         enable;
   logic [3:0]   req;
   logic [15:0]  req_addr;
   logic [127:0] req_data;
   logic [3:0]   gnt;
   logic         rf_write_en;
   logic [3:0]   rf_add_line;
   logic [31:0]  rf_data;
   logic [1:0]   last_master;
   logic         busy;

   int errors = 0;
   int checks = 0;
   int strobe_cnt = 0;
   logic [31:0] bank_m [16];

   regfile_wr_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .enable(enable), .req(req),
      .req_addr(req_addr), .req_data(req_data), .gnt(gnt),
      .rf_write_en(rf_write_en), .rf_add_line(rf_add_line), .rf_data(rf_data),
      .last_master(last_master), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank model: sample the registered write stage in the middle of each cycle.
   always @(negedge clk) begin
      if (rf_write_en === 1'b1) begin
         bank_m[rf_add_line] = rf_data;
         strobe_cnt = strobe_cnt + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_master(input int i, input logic [3:0] a, input logic [31:0] d);
      req_addr[i*4 +: 4]   = a;
      req_data[i*32 +: 32] = d;
   endtask

   task automatic default_masters();
      for (int i = 0; i < 4; i++) set_master(i, 4'(i + 4), 32'hA000_0000 + 32'(i));
   endtask

   task automatic do_reset();
      req = 4'b0000;
      enable = 1'b1;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      default_masters();
      do_reset();
      reset = 1'b1;
      #1;
      checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_write_en); end
      checks++; if (rf_add_line !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", rf_add_line); end
      checks++; if (rf_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", rf_data); end
      checks++; if (last_master !== 2'd0) begin errors++; $display("FAIL reset_last: got %0d want 0", last_master); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      reset = 1'b0;
      req = 4'b1111;
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b want 0001", gnt); end
      tick();
      checks++; if (rf_write_en !== 1'b1 || last_master !== 2'd0) begin errors++; $display("FAIL stream_w0: we=%b last=%0d want we=1 last=0", rf_write_en, last_master); end
      tick();
      // Reset lands mid-stream: strobe and grant drop without waiting for a clock.
      reset = 1'b1;
      #1;
      checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL midreset_we: got %b want 0", rf_write_en); end
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL midreset_gnt: got %b want 0000", gnt); end
      checks++; if (last_master !== 2'd0) begin errors++; $display("FAIL midreset_last: got %0d want 0", last_master); end
      reset = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL postreset_gnt: got %b want 0001", gnt); end
      req = 4'b0000;
      tick();
      $display("test_reset done: errors=%0d", errors);
   endtask

   task automatic test_single();
      do_reset();
      set_master(2, 4'h7, 32'hDEADBEEF);
      req = 4'b0100;
      #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b want 0100", gnt); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_req: got %b want 1", busy); end
      tick();
      checks++; if (rf_write_en !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", rf_write_en); end
      checks++; if (rf_add_line !== 4'h7) begin errors++; $display("FAIL single_addr: got %h want 7", rf_add_line); end
      checks++; if (rf_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h want deadbeef", rf_data); end
      checks++; if (last_master !== 2'd2) begin errors++; $display("FAIL single_last: got %0d want 2", last_master); end
      req = 4'b0000;
      #1;
      checks++; if (gnt !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL single_drop: gnt=%b busy=%b want 0000/1", gnt, busy); end
      tick();
      checks++; if (rf_write_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: we=%b busy=%b want 0/0", rf_write_en, busy); end
      checks++; if (rf_add_line !== 4'h7 || rf_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold: addr=%h data=%h want 7/deadbeef", rf_add_line, rf_data); end
      $display("test_single done: errors=%0d", errors);
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_gnt;
      int m;
      default_masters();
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         m = c % 4;
         exp_gnt = 4'b0001 << m;
         #1;
         checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt, exp_gnt); end
         tick();
         checks++; if (rf_write_en !== 1'b1 || last_master !== 2'(m) || rf_add_line !== 4'(m + 4))
            begin errors++; $display("FAIL rr_write[%0d]: we=%b last=%0d addr=%h want 1/%0d/%h", c, rf_write_en, last_master, rf_add_line, m, m + 4); end
      end
      req = 4'b0000;
      tick();
      checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL rr_end_we: got %b want 0", rf_write_en); end
      $display("test_back_to_back done: errors=%0d", errors);
   endtask

   task automatic test_wrap();
      default_masters();
      do_reset();
      req = 4'b0100;
      #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_setup: got %b want 0100", gnt); end
      tick();
      req = 4'b0101;
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0: got %b want 0001", gnt); end
      tick();
      checks++; if (last_master !== 2'd0) begin errors++; $display("FAIL wrap_last0: got %0d want 0", last_master); end
      #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_gnt2: got %b want 0100", gnt); end
      tick();
      checks++; if (last_master !== 2'd2) begin errors++; $display("FAIL wrap_last2: got %0d want 2", last_master); end
      req = 4'b1111;
      #1;
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_ptr3: got %b want 1000", gnt); end
      req = 4'b0000;
      tick();
      $display("test_wrap done: errors=%0d", errors);
   endtask

   task automatic test_enable();
      default_masters();
      do_reset();
      req = 4'b0011;
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL en_gnt0: got %b want 0001", gnt); end
      tick();
      enable = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL en_off_gnt: got %b want 0000", gnt); end
      checks++; if (rf_write_en !== 1'b1 || last_master !== 2'd0) begin errors++; $display("FAIL en_inflight: we=%b last=%0d want 1/0", rf_write_en, last_master); end
      tick();
      checks++; if (rf_write_en !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL en_off_idle1: we=%b gnt=%b want 0/0000", rf_write_en, gnt); end
      tick();
      checks++; if (rf_write_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL en_off_idle2: we=%b busy=%b want 0/1", rf_write_en, busy); end
      enable = 1'b1;
      #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL en_resume_gnt: got %b want 0010", gnt); end
      tick();
      checks++; if (rf_write_en !== 1'b1 || last_master !== 2'd1) begin errors++; $display("FAIL en_resume_write: we=%b last=%0d want 1/1", rf_write_en, last_master); end
      req = 4'b0000;
      tick();
      $display("test_enable done: errors=%0d", errors);
   endtask

   task automatic test_same_addr();
      int start_cnt;
      default_masters();
      do_reset();
      bank_m[10] = 32'h0;
      start_cnt = strobe_cnt;
      set_master(0, 4'hA, 32'h1);
      set_master(1, 4'hA, 32'h2);
      req = 4'b0011;
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL same_gnt0: got %b want 0001", gnt); end
      tick();
      req = 4'b0010;
      #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL same_gnt1: got %b want 0010", gnt); end
      checks++; if (rf_data !== 32'h1) begin errors++; $display("FAIL same_first_data: got %h want 1", rf_data); end
      tick();
      req = 4'b0000;
      tick();
      tick();
      checks++; if (strobe_cnt - start_cnt !== 2) begin errors++; $display("FAIL same_strobes: got %0d want 2", strobe_cnt - start_cnt); end
      checks++; if (bank_m[10] !== 32'h2) begin errors++; $display("FAIL same_bank: got %h want 2", bank_m[10]); end
      checks++; if (rf_data !== 32'h2 || rf_add_line !== 4'hA) begin errors++; $display("FAIL same_final: data=%h addr=%h want 2/a", rf_data, rf_add_line); end
      $display("test_same_addr done: errors=%0d", errors);
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b1;
      req = 4'b0000;
      req_addr = '0;
      req_data = '0;
      for (int i = 0; i < 16; i++) bank_m[i] = 32'h0;
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap();
      test_enable();
      test_same_addr();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
